// File: rtl/vid_mem_target.sv
//==============================================================================
// Module   : vid_mem_target
// Purpose  : Bus target serving read/write bursts for the pixel-fetch master.
//            Optional request range checking is enabled by defining ADDR_CHECK_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module vid_mem_target #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
    parameter int          RD_LAT    = 2,
    parameter logic [3:0]  DEST_ID   = 4'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        selin,
    input  logic [2:0]  cmdin,
    input  logic [1:0]  lenin,
    input  logic [31:0] addrdatain,
    input  logic        ackin,
    output logic [1:0]  reqout,
    output logic [1:0]  lenout,
    output logic [31:0] addrdataout,
    output logic [2:0]  cmdout,
    output logic [3:0]  reqtar,
    output logic        busy
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = (RD_LAT > 8) ? $clog2(RD_LAT) : 3;
    localparam logic [CNT_W-1:0] c_LAT_LAST = CNT_W'(RD_LAT - 1);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_RD_WAIT = 3'd1;
    localparam logic [2:0] c_RD_BID  = 3'd2;
    localparam logic [2:0] c_RD_DATA = 3'd3;
    localparam logic [2:0] c_WR_DATA = 3'd4;
    localparam logic [2:0] c_WR_BID  = 3'd5;
    localparam logic [2:0] c_WR_RESP = 3'd6;

    localparam logic [2:0] c_CMD_WDATA = 3'b001;
    localparam logic [2:0] c_CMD_RREQ  = 3'b010;
    localparam logic [2:0] c_CMD_RDATA = 3'b011;
    localparam logic [2:0] c_CMD_WREQ  = 3'b100;
    localparam logic [2:0] c_CMD_WRESP = 3'b101;
    localparam logic [2:0] c_CMD_ERR   = 3'b110;

    logic [31:0]      mem_q [DEPTH];
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [1:0]       len_q, len_d;
    logic             err_q, err_d;
    logic             w_we;
    logic             w_range_err;
    logic [AW-1:0]    w_start_idx;
    logic [2:0]       w_last_cnt;
    logic             w_last_beat;

    logic [1:0]  reqout_q, reqout_d;
    logic [1:0]  lenout_q, lenout_d;
    logic [31:0] data_q, data_d;
    logic [2:0]  cmdout_q, cmdout_d;
    logic [3:0]  reqtar_q, reqtar_d;
    logic        busy_q, busy_d;

    assign w_start_idx = AW'((addrdatain - BASE_ADDR) >> 2);
    assign w_last_cnt  = 3'((4'd1 << len_q) - 4'd1);
    assign w_last_beat = (cnt_q == CNT_W'(w_last_cnt));

`ifdef ADDR_CHECK_EN
    // Range is judged on the word-aligned first and last beat of the request
    localparam logic [32:0] c_LO = {1'b0, BASE_ADDR};
    localparam logic [32:0] c_HI = c_LO + 33'(4 * DEPTH);
    logic [2:0]  w_req_last;
    logic [32:0] w_first;
    logic [32:0] w_last;
    assign w_req_last  = 3'((4'd1 << lenin) - 4'd1);
    assign w_first     = {1'b0, addrdatain[31:2], 2'b00};
    assign w_last      = w_first + {28'd0, w_req_last, 2'b00};
    assign w_range_err = (w_first < c_LO) || (w_last >= c_HI);
`else
    assign w_range_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= c_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            len_q    <= '0;
            err_q    <= 1'b0;
            reqout_q <= '0;
            lenout_q <= '0;
            data_q   <= '0;
            cmdout_q <= '0;
            reqtar_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            err_q    <= err_d;
            reqout_q <= reqout_d;
            lenout_q <= lenout_d;
            data_q   <= data_d;
            cmdout_q <= cmdout_d;
            reqtar_q <= reqtar_d;
            busy_q   <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we && !reset) begin
            mem_q[idx_q] <= addrdatain;
        end
    end

    // idx_q always points at the next word to be read or written
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        len_d   = len_q;
        err_d   = err_q;
        w_we    = 1'b0;
        case (state_q)
            c_IDLE: begin
                if (selin && (cmdin == c_CMD_RREQ || cmdin == c_CMD_WREQ)) begin
                    state_d = (cmdin == c_CMD_RREQ) ? c_RD_WAIT : c_WR_DATA;
                    cnt_d   = '0;
                    idx_d   = w_start_idx;
                    len_d   = lenin;
                    err_d   = w_range_err;
                end
            end
            c_RD_WAIT: begin
                if (cnt_q == c_LAT_LAST) begin
                    state_d = c_RD_BID;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            c_RD_BID: begin
                if (ackin) begin
                    state_d = c_RD_DATA;
                    cnt_d   = '0;
                    idx_d   = idx_q + AW'(1);
                end
            end
            c_RD_DATA: begin
                if (err_q || w_last_beat) begin
                    state_d = c_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    idx_d = idx_q + AW'(1);
                end
            end
            c_WR_DATA: begin
                if (cmdin == c_CMD_WDATA) begin
                    w_we  = !err_q;
                    idx_d = idx_q + AW'(1);
                    if (w_last_beat) begin
                        state_d = c_WR_BID;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (cmdin != 3'b000) begin
                    state_d = c_IDLE;
                end
            end
            c_WR_BID: begin
                if (ackin) begin
                    state_d = c_WR_RESP;
                end
            end
            c_WR_RESP: state_d = c_IDLE;
            default:   state_d = c_IDLE;
        endcase
    end

    always_comb begin
        reqout_d = 2'b00;
        lenout_d = 2'b00;
        data_d   = '0;
        cmdout_d = 3'b000;
        case (state_d)
            c_RD_BID, c_WR_BID: reqout_d = 2'b11;
            c_RD_DATA: begin
                reqout_d = 2'b11;
                if (err_d) begin
                    cmdout_d = c_CMD_ERR;
                    data_d   = 32'hDEAD_0001;
                end else begin
                    cmdout_d = c_CMD_RDATA;
                    lenout_d = len_d;
                    data_d   = mem_q[idx_q];
                end
            end
            c_WR_RESP: begin
                cmdout_d = err_d ? c_CMD_ERR : c_CMD_WRESP;
                data_d   = err_d ? 32'd1 : 32'd0;
            end
            default: ;
        endcase
        reqtar_d = (reqout_d != 2'b00 || cmdout_d != 3'b000) ? DEST_ID : 4'h0;
        busy_d   = (state_d != c_IDLE);
    end

    assign reqout      = reqout_q;
    assign lenout      = lenout_q;
    assign addrdataout = data_q;
    assign cmdout      = cmdout_q;
    assign reqtar      = reqtar_q;
    assign busy        = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_vid_mem_target.sv
//==============================================================================
// Module   : tb_vid_mem_target
// Purpose  : Randomized self-checking bench for vid_mem_target against a
//            word-array reference model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_vid_mem_target;

    localparam int          DEPTH  = 1024;
    localparam logic [31:0] BASE   = 32'h0001_0000;
    localparam int          RD_LAT = 2;
    localparam logic [3:0]  DEST   = 4'hA;

    logic        clk = 1'b0;
    logic        reset;
    logic        selin;
    logic [2:0]  cmdin;
    logic [1:0]  lenin;
    logic [31:0] addrdatain;
    logic        ackin;
    logic [1:0]  reqout;
    logic [1:0]  lenout;
    logic [31:0] addrdataout;
    logic [2:0]  cmdout;
    logic [3:0]  reqtar;
    logic        busy;

    int          vectors    = 0;
    int          miscompares = 0;
    logic [31:0] model [DEPTH];
    logic [31:0] wdata_q [$];

    vid_mem_target #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE),
        .RD_LAT    (RD_LAT),
        .DEST_ID   (DEST)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .selin       (selin),
        .cmdin       (cmdin),
        .lenin       (lenin),
        .addrdatain  (addrdatain),
        .ackin       (ackin),
        .reqout      (reqout),
        .lenout      (lenout),
        .addrdataout (addrdataout),
        .cmdout      (cmdout),
        .reqtar      (reqtar),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int idx_of(input logic [31:0] a);
        logic [31:0] off;
        off = (a - BASE) >> 2;
        return int'(off % 32'(DEPTH));
    endfunction

    function automatic bit range_err(input logic [31:0] a, input int n);
`ifdef ADDR_CHECK_EN
        longint first;
        longint last;
        first = longint'({32'd0, a[31:2], 2'b00});
        last  = first + 4 * n - 4;
        return (first < longint'({32'd0, BASE})) || (last >= longint'({32'd0, BASE}) + 4 * DEPTH);
`else
        return 1'b0;
`endif
    endfunction

    task automatic do_read(input logic [31:0] addr, input logic [1:0] len, input int ack_dly,
                           input bit extra_req, input int rst_beat);
        int n;
        bit err;
        int bi;
        int cyc;
        logic [31:0] exp;
        n   = 1 << len;
        err = range_err(addr, n);
        bi  = idx_of(addr);
        selin = 1'b1; cmdin = 3'b010; lenin = len; addrdatain = addr;
        step();
        selin = 1'b0; cmdin = 3'b000; addrdatain = $urandom;
        vectors++;
        if (busy !== 1'b1 || reqout !== 2'b00) begin
            miscompares++;
            $display("FAIL rd_capture: busy=%b reqout=%b, expected busy=1 reqout=00", busy, reqout);
        end
        cyc = 0;
        while (reqout !== 2'b11 && cyc < 64) begin
            step();
            cyc++;
        end
        vectors++;
        if (cyc != RD_LAT) begin
            miscompares++;
            $display("FAIL rd_bid_latency: bid after %0d cycles, expected %0d", cyc, RD_LAT);
        end
        for (int i = 0; i < ack_dly; i++) begin
            if (extra_req) begin
                selin = 1'b1; cmdin = 3'b010; lenin = 2'($urandom); addrdatain = BASE + 32'h40;
            end
            step();
            selin = 1'b0; cmdin = 3'b000;
            vectors++;
            if (reqout !== 2'b11 || cmdout !== 3'b000 || reqtar !== DEST) begin
                miscompares++;
                $display("FAIL rd_bid_hold: reqout=%b cmdout=%b reqtar=%h, expected 11/000/%h",
                         reqout, cmdout, reqtar, DEST);
            end
        end
        ackin = 1'b1;
        step();
        ackin = 1'b0;
        if (err) begin
            vectors++;
            if (cmdout !== 3'b110 || lenout !== 2'b00 || addrdataout !== 32'hDEAD_0001 || reqout !== 2'b11) begin
                miscompares++;
                $display("FAIL rd_err_beat: cmd=%b len=%b data=%h reqout=%b, expected 110/00/dead0001/11",
                         cmdout, lenout, addrdataout, reqout);
            end
            step();
        end else begin
            for (int k = 0; k < n; k++) begin
                if (k == rst_beat) begin
                    reset = 1'b1;
                    step();
                    reset = 1'b0;
                    vectors++;
                    if ({reqout, lenout, addrdataout, cmdout, reqtar, busy} !== '0) begin
                        miscompares++;
                        $display("FAIL rd_reset_mid: reqout=%b len=%b data=%h cmd=%b tar=%h busy=%b, expected all 0",
                                 reqout, lenout, addrdataout, cmdout, reqtar, busy);
                    end
                    return;
                end
                exp = model[(bi + k) % DEPTH];
                vectors++;
                if (cmdout !== 3'b011 || lenout !== len || addrdataout !== exp ||
                    reqout !== 2'b11 || reqtar !== DEST) begin
                    miscompares++;
                    $display("FAIL rd_beat k=%0d: cmd=%b len=%b data=%h reqout=%b tar=%h, expected 011/%b/%h/11/%h",
                             k, cmdout, lenout, addrdataout, reqout, reqtar, len, exp, DEST);
                end
                step();
            end
        end
        vectors++;
        if (cmdout !== 3'b000 || reqout !== 2'b00 || busy !== 1'b0 || reqtar !== 4'h0) begin
            miscompares++;
            $display("FAIL rd_end_idle: cmd=%b reqout=%b busy=%b tar=%h, expected 000/00/0/0",
                     cmdout, reqout, busy, reqtar);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [1:0] len, input int ack_dly,
                            input int fixed_stall, input int abort_after);
        int n;
        bit err;
        int bi;
        int stalls;
        logic [31:0] d;
        n   = 1 << len;
        err = range_err(addr, n);
        bi  = idx_of(addr);
        selin = 1'b1; cmdin = 3'b100; lenin = len; addrdatain = addr;
        step();
        selin = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (k == abort_after) begin
                cmdin = 3'b010; addrdatain = $urandom;
                step();
                cmdin = 3'b000;
                repeat (3) step();
                vectors++;
                if (busy !== 1'b0 || reqout !== 2'b00 || cmdout !== 3'b000) begin
                    miscompares++;
                    $display("FAIL wr_abort: busy=%b reqout=%b cmd=%b, expected 0/00/000", busy, reqout, cmdout);
                end
                return;
            end
            stalls = (fixed_stall >= 0) ? ((k > 0) ? fixed_stall : 0) : int'($urandom_range(0, 2));
            repeat (stalls) begin
                cmdin = 3'b000; addrdatain = $urandom;
                step();
            end
            d = (wdata_q.size() > 0) ? wdata_q.pop_front() : $urandom;
            cmdin = 3'b001; addrdatain = d;
            step();
            if (!err) model[(bi + k) % DEPTH] = d;
        end
        cmdin = 3'b000;
        vectors++;
        if (reqout !== 2'b11 || cmdout !== 3'b000 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL wr_bid: reqout=%b cmd=%b busy=%b, expected 11/000/1", reqout, cmdout, busy);
        end
        for (int i = 0; i < ack_dly; i++) begin
            step();
            vectors++;
            if (reqout !== 2'b11 || cmdout !== 3'b000) begin
                miscompares++;
                $display("FAIL wr_bid_hold: reqout=%b cmd=%b, expected 11/000", reqout, cmdout);
            end
        end
        ackin = 1'b1;
        step();
        ackin = 1'b0;
        vectors++;
        if (cmdout !== (err ? 3'b110 : 3'b101) || addrdataout !== (err ? 32'd1 : 32'd0) ||
            reqout !== 2'b00 || reqtar !== DEST) begin
            miscompares++;
            $display("FAIL wr_resp: cmd=%b data=%h reqout=%b tar=%h, expected %b/%0d/00/%h",
                     cmdout, addrdataout, reqout, reqtar, (err ? 3'b110 : 3'b101), err, DEST);
        end
        step();
        vectors++;
        if (cmdout !== 3'b000 || busy !== 1'b0 || reqtar !== 4'h0) begin
            miscompares++;
            $display("FAIL wr_end_idle: cmd=%b busy=%b tar=%h, expected 000/0/0", cmdout, busy, reqtar);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; selin = 1'b1; cmdin = 3'b010; lenin = 2'b11; ackin = 1'b1; addrdatain = BASE;
        repeat (3) step();
        vectors++;
        if ({reqout, lenout, addrdataout, cmdout, reqtar, busy} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: reqout=%b len=%b data=%h cmd=%b tar=%h busy=%b, expected all 0",
                     reqout, lenout, addrdataout, cmdout, reqtar, busy);
        end
        reset = 1'b0; selin = 1'b0; cmdin = 3'b000; ackin = 1'b0;
        repeat (2) step();
        vectors++;
        if (busy !== 1'b0 || reqout !== 2'b00 || cmdout !== 3'b000) begin
            miscompares++;
            $display("FAIL idle_after_reset: busy=%b reqout=%b cmd=%b, expected 0/00/000", busy, reqout, cmdout);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH / 8; i++) do_write(BASE + 32'(32 * i), 2'b11, 0, 0, -1);
    endtask

    task automatic test_read();
        do_write(BASE, 2'b10, 0, 0, -1);
        do_read(BASE, 2'b10, 1, 1'b0, -1);
    endtask

    task automatic test_write_stall();
        wdata_q.push_back(32'h0000_0011);
        wdata_q.push_back(32'h0000_0022);
        do_write(BASE + 32'd8, 2'b01, 2, 1, -1);
        do_read(BASE + 32'd8, 2'b01, 0, 1'b0, -1);
    endtask

    task automatic test_wrap();
        do_write(BASE + 32'(4 * (DEPTH - 2)), 2'b10, 0, -1, -1);
        do_read(BASE + 32'(4 * (DEPTH - 2)), 2'b10, 1, 1'b0, -1);
    endtask

    task automatic test_bid_hold();
        do_read(BASE + 32'h40, 2'b01, 5, 1'b1, -1);
        repeat (RD_LAT + 4) begin
            step();
            vectors++;
            if (reqout !== 2'b00 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL no_second_burst: reqout=%b busy=%b, expected 00/0", reqout, busy);
            end
        end
    endtask

    task automatic test_reset_midburst();
        do_read(BASE + 32'h100, 2'b11, 0, 1'b0, 1);
        do_read(BASE + 32'h200, 2'b11, 0, 1'b0, -1);
    endtask

    task automatic test_write_abort();
        do_write(BASE + 32'h300, 2'b10, 0, 0, 2);
        do_read(BASE + 32'h300, 2'b10, 0, 1'b0, -1);
    endtask

`ifdef ADDR_CHECK_EN
    task automatic test_addr_check();
        do_read(BASE - 32'd4, 2'b00, 0, 1'b0, -1);
        do_write(BASE + 32'(4 * DEPTH - 4), 2'b01, 1, 0, -1);
        do_read(BASE + 32'(4 * DEPTH - 4), 2'b00, 0, 1'b0, -1);
    endtask
`endif

    task automatic test_random();
        logic [31:0] a;
        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(0, 3) == 0) a = $urandom;
            else a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                do_write(a, 2'($urandom), int'($urandom_range(0, 3)), -1, -1);
            else
                do_read(a, 2'($urandom), int'($urandom_range(0, 3)), 1'($urandom), -1);
        end
    endtask

    initial begin
        reset = 1'b1; selin = 1'b0; cmdin = 3'b000; lenin = 2'b00; addrdatain = '0; ackin = 1'b0;
        test_reset();
        test_fill();
        test_read();
        test_write_stall();
        test_wrap();
        test_bid_hold();
        test_reset_midburst();
        test_write_abort();
`ifdef ADDR_CHECK_EN
        test_addr_check();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
